legv8_control_unit: RTL and testbench

Multicycle control unit for the LEGv8 datapath. It latches the 32-bit instruction from the program ROM, decodes it and sequences one control word per cycle into the datapath: register selects, ALU function, bus enables, RAM strobes, status capture and PC update. Status flags come back through `PRESTAT` for conditional branches. It sits beside the datapath in the CPU top level and is its only source of control.

---
 rtl/legv8_ctrl_pkg.sv | 72 +++++++
 rtl/legv8_decode.sv | 69 ++++++
 rtl/legv8_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_legv8_control_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multicycle control unit.
// Optional illegal-opcode trap is enabled with CU_ILLEGAL_TRAP_EN (see top).
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_BRCHK = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_RTYPE = 4'd1,
        CLS_ITYPE = 4'd2,
        CLS_LDUR  = 4'd3,
        CLS_STUR  = 4'd4,
        CLS_B     = 4'd5,
        CLS_CBZ   = 4'd6,
        CLS_CBNZ  = 4'd7,
        CLS_HLT   = 4'd8
    } inst_cls_e;

    localparam logic [10:0] OP11_ADD  = 11'h458;
    localparam logic [10:0] OP11_SUB  = 11'h658;
    localparam logic [10:0] OP11_AND  = 11'h450;
    localparam logic [10:0] OP11_ORR  = 11'h550;
    localparam logic [10:0] OP11_LDUR = 11'h7C2;
    localparam logic [10:0] OP11_STUR = 11'h7C0;
    localparam logic [9:0]  OP10_ADDI = 10'h244;
    localparam logic [9:0]  OP10_SUBI = 10'h344;
    localparam logic [7:0]  OP8_CBZ   = 8'hB4;
    localparam logic [7:0]  OP8_CBNZ  = 8'hB5;
    localparam logic [5:0]  OP6_B     = 6'h05;
    localparam logic [31:0] HLT_WORD  = 32'hFFFF_FFFF;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       wr;
        logic [4:0] fs;
        logic       c0;
        logic       m;
        logic       en_alu;
        logic       en_addr_alu;
        logic       en_b;
        logic       en_pc;
        logic       en_addr_pc;
        logic       pc_sel;
        logic       br_sel;
        logic [1:0] ps;
        logic       rcs;
        logic       rwe;
        logic       roe;
        logic       sfl;
    } ctrl_word_t;

    localparam ctrl_word_t CW_DEFAULT = '0;

endpackage

// File: rtl/legv8_decode.sv
// Combinational instruction classifier: IR -> class, ALU function and
// immediates already extended to the datapath width.
module legv8_decode
    import legv8_ctrl_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [31:0]   ir,
    output inst_cls_e     cls,
    output logic [4:0]    alu_fs,
    output logic          alu_c0,
    output logic [DW-1:0] imm12_k,
    output logic [DW-1:0] dt9_k,
    output logic [DW-1:0] imm19_k,
    output logic [DW-1:0] imm26_k
);

    assign imm12_k = {{(DW-12){1'b0}}, ir[21:10]};
    assign dt9_k   = {{(DW-9){ir[20]}}, ir[20:12]};
    assign imm19_k = {{(DW-19){ir[23]}}, ir[23:5]};
    assign imm26_k = {{(DW-26){ir[25]}}, ir[25:0]};

    // Opcode classification; HLT is matched on the full word first
    always_comb begin
        cls    = CLS_NOP;
        alu_fs = FS_AND;
        alu_c0 = 1'b0;
        if (ir == HLT_WORD) begin
            cls = CLS_HLT;
        end else if (ir[31:21] == OP11_ADD) begin
            cls    = CLS_RTYPE;
            alu_fs = FS_ADD;
        end else if (ir[31:21] == OP11_SUB) begin
            cls    = CLS_RTYPE;
            alu_fs = FS_SUB;
            alu_c0 = 1'b1;
        end else if (ir[31:21] == OP11_AND) begin
            cls    = CLS_RTYPE;
            alu_fs = FS_AND;
        end else if (ir[31:21] == OP11_ORR) begin
            cls    = CLS_RTYPE;
            alu_fs = FS_ORR;
        end else if (ir[31:21] == OP11_LDUR) begin
            cls    = CLS_LDUR;
            alu_fs = FS_ADD;
        end else if (ir[31:21] == OP11_STUR) begin
            cls    = CLS_STUR;
            alu_fs = FS_ADD;
        end else if (ir[31:22] == OP10_ADDI) begin
            cls    = CLS_ITYPE;
            alu_fs = FS_ADD;
        end else if (ir[31:22] == OP10_SUBI) begin
            cls    = CLS_ITYPE;
            alu_fs = FS_SUB;
            alu_c0 = 1'b1;
        end else if (ir[31:24] == OP8_CBZ) begin
            cls    = CLS_CBZ;
            alu_fs = FS_ADD;
        end else if (ir[31:24] == OP8_CBNZ) begin
            cls    = CLS_CBNZ;
            alu_fs = FS_ADD;
        end else if (ir[31:26] == OP6_B) begin
            cls = CLS_B;
        end else begin
            cls = CLS_NOP;
        end
    end

endmodule

// File: rtl/legv8_control_unit.sv
// LEGv8 multicycle control unit: FSM plus control-word mux.
// Define CU_ILLEGAL_TRAP_EN to trap undecoded opcodes into HALT with illegal=1.
module legv8_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RUN,
    input  logic [31:0]   inst,
    input  logic [3:0]    PRESTAT,
    output logic [4:0]    SA,
    output logic [4:0]    SB,
    output logic [4:0]    DA,
    output logic          WR,
    output logic [4:0]    FS,
    output logic          C0,
    output logic [DW-1:0] K,
    output logic          M,
    output logic          EN_ALU,
    output logic          EN_ADDR_ALU,
    output logic          EN_B,
    output logic          EN_PC,
    output logic          EN_ADDR_PC,
    output logic          PC_SEL,
    output logic          BR_SEL,
    output logic [1:0]    PS,
    output logic          RCS,
    output logic          RWE,
    output logic          ROE,
    output logic          SFL,
    output logic          halted,
    output logic          illegal
);

    state_e        state_q, state_d;
    logic [31:0]   ir_q, ir_d;
    logic          illegal_q, illegal_d;
    ctrl_word_t    cw_s;
    logic [DW-1:0] k_s;
    inst_cls_e     cls_s;
    logic [4:0]    alu_fs_s;
    logic          alu_c0_s;
    logic [DW-1:0] imm12_k_s, dt9_k_s, imm19_k_s, imm26_k_s;
    logic [4:0]    rd_s, rn_s, rm_s;
    logic          unused_flags_s;

    // Only Z is consumed by the branch check
    assign unused_flags_s = ^PRESTAT[3:1];

    assign rd_s = ir_q[4:0];
    assign rn_s = ir_q[9:5];
    assign rm_s = ir_q[20:16];

    legv8_decode #(.DW(DW)) u_decode (
        .ir      (ir_q),
        .cls     (cls_s),
        .alu_fs  (alu_fs_s),
        .alu_c0  (alu_c0_s),
        .imm12_k (imm12_k_s),
        .dt9_k   (dt9_k_s),
        .imm19_k (imm19_k_s),
        .imm26_k (imm26_k_s)
    );

    // State, instruction and trap-flag registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control word; RST forces the default word in its own cycle
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        cw_s      = CW_DEFAULT;
        k_s       = {DW{1'b0}};
        if (RST) begin
            cw_s = CW_DEFAULT;
            k_s  = {DW{1'b0}};
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (RUN) begin
                        ir_d    = inst;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (cls_s)
                        CLS_RTYPE: begin
                            cw_s.sa = rn_s; cw_s.sb = rm_s; cw_s.da = rd_s;
                            cw_s.fs = alu_fs_s; cw_s.c0 = alu_c0_s;
                            cw_s.en_alu = 1'b1; cw_s.wr = 1'b1; cw_s.ps = PS_INC;
                        end
                        CLS_ITYPE: begin
                            cw_s.sa = rn_s; cw_s.da = rd_s; cw_s.m = 1'b1; k_s = imm12_k_s;
                            cw_s.fs = alu_fs_s; cw_s.c0 = alu_c0_s;
                            cw_s.en_alu = 1'b1; cw_s.wr = 1'b1; cw_s.ps = PS_INC;
                        end
                        CLS_LDUR: begin
                            cw_s.sa = rn_s; cw_s.m = 1'b1; k_s = dt9_k_s; cw_s.fs = FS_ADD;
                            cw_s.en_addr_alu = 1'b1; cw_s.rcs = 1'b1; cw_s.roe = 1'b1;
                            state_d = S_MEM;
                        end
                        CLS_STUR: begin
                            cw_s.sa = rn_s; cw_s.m = 1'b1; k_s = dt9_k_s; cw_s.fs = FS_ADD;
                            cw_s.en_addr_alu = 1'b1; cw_s.sb = rd_s; cw_s.en_b = 1'b1;
                            cw_s.rcs = 1'b1; cw_s.rwe = 1'b1; cw_s.ps = PS_INC;
                        end
                        CLS_B: begin
                            k_s = imm26_k_s; cw_s.br_sel = 1'b1; cw_s.pc_sel = 1'b1;
                            cw_s.ps = PS_REL;
                        end
                        CLS_CBZ, CLS_CBNZ: begin
                            // Pass Rt through the ALU so the datapath registers its Z flag
                            cw_s.sa = rd_s; cw_s.m = 1'b1; cw_s.fs = FS_ADD; cw_s.sfl = 1'b1;
                            state_d = S_BRCHK;
                        end
                        CLS_HLT: begin
                            state_d = S_HALT;
                        end
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
`else
                            cw_s.ps = PS_INC;
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    cw_s.sa = rn_s; cw_s.m = 1'b1; k_s = dt9_k_s; cw_s.fs = FS_ADD;
                    cw_s.en_addr_alu = 1'b1; cw_s.rcs = 1'b1; cw_s.roe = 1'b1;
                    cw_s.da = rd_s; cw_s.wr = 1'b1; cw_s.ps = PS_INC;
                    state_d = S_FETCH;
                end
                S_BRCHK: begin
                    if (((cls_s == CLS_CBZ) && PRESTAT[0]) || ((cls_s == CLS_CBNZ) && !PRESTAT[0])) begin
                        k_s = imm19_k_s; cw_s.br_sel = 1'b1; cw_s.pc_sel = 1'b1;
                        cw_s.ps = PS_REL;
                    end else begin
                        cw_s.ps = PS_INC;
                    end
                    state_d = S_FETCH;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign SA          = cw_s.sa;
    assign SB          = cw_s.sb;
    assign DA          = cw_s.da;
    assign WR          = cw_s.wr;
    assign FS          = cw_s.fs;
    assign C0          = cw_s.c0;
    assign K           = k_s;
    assign M           = cw_s.m;
    assign EN_ALU      = cw_s.en_alu;
    assign EN_ADDR_ALU = cw_s.en_addr_alu;
    assign EN_B        = cw_s.en_b;
    assign EN_PC       = cw_s.en_pc;
    assign EN_ADDR_PC  = cw_s.en_addr_pc;
    assign PC_SEL      = cw_s.pc_sel;
    assign BR_SEL      = cw_s.br_sel;
    assign PS          = cw_s.ps;
    assign RCS         = cw_s.rcs;
    assign RWE         = cw_s.rwe;
    assign ROE         = cw_s.roe;
    assign SFL         = cw_s.sfl;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Bench for legv8_control_unit: directed checks plus randomized instruction
// stream compared every cycle against a step-counting reference model.
module tb_legv8_control_unit;

    localparam int DW = 64;
`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST, RUN;
    logic [31:0]   inst;
    logic [3:0]    PRESTAT;
    logic [4:0]    SA, SB, DA, FS;
    logic          WR, C0, M, EN_ALU, EN_ADDR_ALU, EN_B, EN_PC, EN_ADDR_PC;
    logic          PC_SEL, BR_SEL, RCS, RWE, ROE, SFL, halted, illegal;
    logic [DW-1:0] K;
    logic [1:0]    PS;

    legv8_control_unit #(.DW(DW)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .inst(inst), .PRESTAT(PRESTAT),
        .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .K(K), .M(M),
        .EN_ALU(EN_ALU), .EN_ADDR_ALU(EN_ADDR_ALU), .EN_B(EN_B), .EN_PC(EN_PC),
        .EN_ADDR_PC(EN_ADDR_PC), .PC_SEL(PC_SEL), .BR_SEL(BR_SEL), .PS(PS),
        .RCS(RCS), .RWE(RWE), .ROE(ROE), .SFL(SFL), .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  sa, sb, da;
        logic        wr;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] k;
        logic        m, en_alu, en_addr_alu, en_b, en_pc, en_addr_pc, pc_sel, br_sel;
        logic [1:0]  ps;
        logic        rcs, rwe, roe, sfl, halted, illegal;
    } obs_t;

    int          total = 0;
    int          bad = 0;
    int          m_step = 0;     // 0 = waiting to fetch, 1 = first cycle after fetch, 2 = second
    logic [31:0] m_ir = 32'h0;
    bit          m_halt = 1'b0;
    bit          m_ill = 1'b0;

    function automatic string kind(input logic [31:0] w);
        if (w == 32'hFFFF_FFFF)      return "hlt";
        if (w[31:21] == 11'h458)     return "add";
        if (w[31:21] == 11'h658)     return "sub";
        if (w[31:21] == 11'h450)     return "and";
        if (w[31:21] == 11'h550)     return "orr";
        if (w[31:21] == 11'h7C2)     return "ldur";
        if (w[31:21] == 11'h7C0)     return "stur";
        if (w[31:22] == 10'h244)     return "addi";
        if (w[31:22] == 10'h344)     return "subi";
        if (w[31:24] == 8'hB4)       return "cbz";
        if (w[31:24] == 8'hB5)       return "cbnz";
        if (w[31:26] == 6'h05)       return "b";
        return "nop";
    endfunction

    function automatic logic [63:0] sext(input longint v, input int bits);
        longint r = v;
        if (((v >> (bits - 1)) & 64'd1) != 64'd0) r = v - (longint'(1) << bits);
        return r;
    endfunction

    function automatic obs_t expect_now();
        obs_t  e = '0;
        string kd = kind(m_ir);
        logic [4:0] rd = m_ir[4:0];
        logic [4:0] rn = m_ir[9:5];
        logic [4:0] rm = m_ir[20:16];
        e.halted  = m_halt;
        e.illegal = m_ill;
        if (RST || m_halt || m_step == 0) return e;
        if (m_step == 1) begin
            if (kd == "add" || kd == "sub" || kd == "and" || kd == "orr") begin
                e.sa = rn; e.sb = rm; e.da = rd; e.wr = 1'b1; e.en_alu = 1'b1; e.ps = 2'd1;
                e.fs = (kd == "add") ? 5'd8 : (kd == "sub") ? 5'd9 : (kd == "orr") ? 5'd4 : 5'd0;
                e.c0 = (kd == "sub");
            end else if (kd == "addi" || kd == "subi") begin
                e.sa = rn; e.da = rd; e.m = 1'b1; e.k = 64'(m_ir[21:10]);
                e.fs = (kd == "addi") ? 5'd8 : 5'd9; e.c0 = (kd == "subi");
                e.wr = 1'b1; e.en_alu = 1'b1; e.ps = 2'd1;
            end else if (kd == "ldur" || kd == "stur") begin
                e.sa = rn; e.m = 1'b1; e.k = sext(longint'(m_ir[20:12]), 9); e.fs = 5'd8;
                e.en_addr_alu = 1'b1; e.rcs = 1'b1;
                if (kd == "ldur") begin
                    e.roe = 1'b1;
                end else begin
                    e.sb = rd; e.en_b = 1'b1; e.rwe = 1'b1; e.ps = 2'd1;
                end
            end else if (kd == "b") begin
                e.k = sext(longint'(m_ir[25:0]), 26); e.br_sel = 1'b1; e.pc_sel = 1'b1; e.ps = 2'd3;
            end else if (kd == "cbz" || kd == "cbnz") begin
                e.sa = rd; e.m = 1'b1; e.fs = 5'd8; e.sfl = 1'b1;
            end else if (kd == "nop" && !TRAP) begin
                e.ps = 2'd1;
            end
        end else if (kd == "ldur") begin
            e.sa = rn; e.m = 1'b1; e.k = sext(longint'(m_ir[20:12]), 9); e.fs = 5'd8;
            e.en_addr_alu = 1'b1; e.rcs = 1'b1; e.roe = 1'b1; e.da = rd; e.wr = 1'b1; e.ps = 2'd1;
        end else if ((kd == "cbz" && PRESTAT[0]) || (kd == "cbnz" && !PRESTAT[0])) begin
            e.k = sext(longint'(m_ir[23:5]), 19); e.br_sel = 1'b1; e.pc_sel = 1'b1; e.ps = 2'd3;
        end else begin
            e.ps = 2'd1;
        end
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t a;
        a.sa = SA; a.sb = SB; a.da = DA; a.wr = WR; a.fs = FS; a.c0 = C0; a.k = K; a.m = M;
        a.en_alu = EN_ALU; a.en_addr_alu = EN_ADDR_ALU; a.en_b = EN_B; a.en_pc = EN_PC;
        a.en_addr_pc = EN_ADDR_PC; a.pc_sel = PC_SEL; a.br_sel = BR_SEL; a.ps = PS;
        a.rcs = RCS; a.rwe = RWE; a.roe = ROE; a.sfl = SFL; a.halted = halted; a.illegal = illegal;
        return a;
    endfunction

    task automatic advance();
        string kd = kind(m_ir);
        if (RST) begin
            m_step = 0; m_ir = 32'h0; m_halt = 1'b0; m_ill = 1'b0;
        end else if (m_halt) begin
            m_step = 0;
        end else if (m_step == 0) begin
            if (RUN) begin
                m_ir = inst; m_step = 1;
            end
        end else if (m_step == 1) begin
            if (kd == "hlt") begin
                m_halt = 1'b1; m_step = 0;
            end else if (kd == "nop" && TRAP) begin
                m_halt = 1'b1; m_ill = 1'b1; m_step = 0;
            end else if (kd == "ldur" || kd == "cbz" || kd == "cbnz") begin
                m_step = 2;
            end else begin
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
    endtask

    task automatic drive(input bit rst, input bit run, input logic [31:0] w, input logic [3:0] fl);
        obs_t e, a;
        @(negedge CLK);
        RST = rst; RUN = run; inst = w; PRESTAT = fl;
        #2;
        e = expect_now();
        a = observe();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL model step=%0d ir=%h got=%h want=%h", m_step, m_ir, a, e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        advance();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r = $urandom;
        logic [10:0] rops [4] = '{11'h458, 11'h658, 11'h450, 11'h550};
        int sel = int'($urandom_range(0, 19));
        if (sel < 4)        r[31:21] = rops[$urandom_range(0, 3)];
        else if (sel < 6)   r[31:22] = ($urandom_range(0, 1) != 0) ? 10'h244 : 10'h344;
        else if (sel < 8)   r[31:21] = 11'h7C2;
        else if (sel < 10)  r[31:21] = 11'h7C0;
        else if (sel < 11)  r[31:26] = 6'h05;
        else if (sel < 14)  r[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'hB5;
        else if (sel < 15)  r = 32'hFFFF_FFFF;
        return r;
    endfunction

    initial begin
        RST = 1'b1; RUN = 1'b0; inst = 32'h0; PRESTAT = 4'h0;
        repeat (2) @(posedge CLK);

        // Reset state
        drive(1'b1, 1'b1, 32'h8B030041, 4'h0);
        chk("rst_wr", 64'(WR), 64'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("idle_ps", 64'(PS), 64'd0);
        chk("idle_halted", 64'(halted), 64'd0);
        chk("idle_illegal", 64'(illegal), 64'd0);
        tick();

        // ADD X1,X2,X3
        drive(1'b0, 1'b1, 32'h8B030041, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("add_sa", 64'(SA), 64'd2); chk("add_sb", 64'(SB), 64'd3);
        chk("add_da", 64'(DA), 64'd1); chk("add_fs", 64'(FS), 64'd8);
        chk("add_wr", 64'(WR), 64'd1); chk("add_ps", 64'(PS), 64'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("add_back_ps", 64'(PS), 64'd0);
        tick();

        // ADDI X1,X2,#5
        drive(1'b0, 1'b1, 32'h91001441, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("addi_m", 64'(M), 64'd1); chk("addi_k", K, 64'd5);
        chk("addi_wr", 64'(WR), 64'd1); chk("addi_da", 64'(DA), 64'd1);
        tick();

        // LDUR X4,[X5,#-8]
        drive(1'b0, 1'b1, 32'hF85F80A4, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("ldur_k", K, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur_addr", 64'(EN_ADDR_ALU), 64'd1); chk("ldur_roe", 64'(ROE), 64'd1);
        chk("ldur_exec_wr", 64'(WR), 64'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("ldur_mem_wr", 64'(WR), 64'd1); chk("ldur_mem_da", 64'(DA), 64'd4);
        chk("ldur_mem_ps", 64'(PS), 64'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("ldur_done_ps", 64'(PS), 64'd0);
        tick();

        // CBZ X6,#+3 taken / not taken, CBNZ taken
        drive(1'b0, 1'b1, 32'hB4000066, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0); chk("cbz_sfl", 64'(SFL), 64'd1); tick();
        drive(1'b0, 1'b0, 32'h0, 4'b0001);
        chk("cbz_t_ps", 64'(PS), 64'd3); chk("cbz_t_k", K, 64'd3);
        tick();
        drive(1'b0, 1'b1, 32'hB4000066, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        chk("cbz_nt_ps", 64'(PS), 64'd1);
        tick();
        drive(1'b0, 1'b1, 32'hB5000066, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        chk("cbnz_t_ps", 64'(PS), 64'd3);
        tick();

        // HLT then reset pulse
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0); tick();
        drive(1'b0, 1'b1, 32'h8B030041, 4'h0); chk("hlt_exec_ps", 64'(PS), 64'd0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 32'h8B030041, 4'($urandom));
            chk("hlt_halted", 64'(halted), 64'd1);
            chk("hlt_wr", 64'(WR), 64'd0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("hlt_cleared", 64'(halted), 64'd0);
        tick();

        // Reset during MEM of LDUR
        drive(1'b0, 1'b1, 32'hF85F80A4, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0); tick();
        drive(1'b1, 1'b0, 32'h0, 4'h0); chk("rst_mem_wr", 64'(WR), 64'd0); tick();
        drive(1'b0, 1'b1, 32'h8B030041, 4'h0); chk("rst_mem_fetch_ps", 64'(PS), 64'd0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0); chk("rst_mem_next_wr", 64'(WR), 64'd1); tick();

        // Undecoded opcode
        drive(1'b0, 1'b1, 32'h0000_0000, 4'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("und_ps", 64'(PS), TRAP ? 64'd0 : 64'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        chk("und_illegal", 64'(illegal), 64'(TRAP));
        chk("und_halted", 64'(halted), 64'(TRAP));
        tick();
        drive(1'b1, 1'b0, 32'h0, 4'h0); tick();

        // Randomized stream against the model
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), gen(), 4'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
